multi_channel_frequency_divider: RTL and testbench

- Parametrised successor to the fixed 2 Hz divider.
- Generates NUM_CH independent square-wave clocks from one system clock, plus a one-cycle tick per output period.
- Each channel's half-period is programmable at run time through a shared config write port, and each channel has its own enable.
- Sits between the board clock and slow consumers such as display scan, LED blink and debounce sampling.

---
 rtl/multi_channel_frequency_divider.sv | 120 ++++++++++++
 tb/tb_multi_channel_frequency_divider.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/multi_channel_frequency_divider.sv
// -----------------------------------------------------------------------------
// multi_channel_frequency_divider
//
// Produces NUM_CH independent 50%-duty square waves from one system clock, plus
// a one-cycle tick on each rising edge of every divided clock. Each channel's
// half-period N is programmable at run time through a shared write port. The
// output period is 2*(N+1) clk_i cycles. A new N written to a running channel
// is held as "pending" and only takes effect at the channel's terminal count,
// so the half-period in progress always finishes with the old value.
//
// Ports
//   clk_i       system clock, rising-edge
//   rst_i       asynchronous reset, active-low
//   en_i        per-channel run enable (bit k -> channel k)
//   cfg_we_i    one-cycle config write strobe
//   cfg_ch_i    channel index for the write (indices >= NUM_CH are ignored)
//   cfg_half_i  new half-period value N
//   clk_o       divided clocks, registered
//   tick_o      one-cycle pulse on each 0->1 edge of clk_o[k], registered
// -----------------------------------------------------------------------------
module multi_channel_frequency_divider #(
  parameter int          NUM_CH       = 4,
  parameter int          CH_W         = 2,
  parameter int          CNT_W        = 26,
  parameter int unsigned DEFAULT_HALF = 24999999
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_half_i,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o
);

  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr;
    logic             terminal;

    // A write whose index is >= NUM_CH matches no channel and is dropped.
    assign wr       = cfg_we_i && (cfg_ch_i == CH_W'(k));
    // Equality (not >=) is safe: act only changes at cnt=0 or with cnt cleared,
    // so cnt can never be above act. It also makes N = 2^CNT_W-1 legal.
    assign terminal = (cnt_q == act_q);

    always_comb begin
      cnt_d      = cnt_q;
      act_d      = act_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      clk_d      = clk_q;
      tick_d     = 1'b0;

      if (en_i[k]) begin
        if (terminal) begin
          cnt_d      = '0;
          clk_d      = ~clk_q;
          // Tick only on the toggle that takes the output from 0 to 1.
          tick_d     = ~clk_q;
          pend_vld_d = 1'b0;
          // A write landing on the terminal edge bypasses pending and wins
          // over any older pending value.
          if (wr) begin
            act_d  = cfg_half_i;
            pend_d = cfg_half_i;
          end else if (pend_vld_q) begin
            act_d  = pend_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Later writes overwrite earlier ones: last write wins.
          if (wr) begin
            pend_d     = cfg_half_i;
            pend_vld_d = 1'b1;
          end
        end
      end else if (wr) begin
        // Paused channel: apply immediately and restart the count so a held
        // count can never sit above the new half-period. Output level holds.
        act_d      = cfg_half_i;
        pend_d     = cfg_half_i;
        pend_vld_d = 1'b0;
        cnt_d      = '0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        cnt_q      <= '0;
        act_q      <= RST_HALF;
        pend_q     <= RST_HALF;
        pend_vld_q <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        act_q      <= act_d;
        pend_q     <= pend_d;
        pend_vld_q <= pend_vld_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
      end
    end

    assign clk_o[k]  = clk_q;
    assign tick_o[k] = tick_q;

  end : g_ch

endmodule

// File: tb/tb_multi_channel_frequency_divider.sv
// -----------------------------------------------------------------------------
// Testbench for multi_channel_frequency_divider.
// dut_a: NUM_CH=4, CNT_W=8, DEFAULT_HALF=3 (period 8 after reset).
// dut_b: NUM_CH=3, same sizes, shares all inputs; used for the out-of-range
//        channel write.
// Inputs change 1 time unit after a rising edge; outputs are read at that same
// point, i.e. just after the edge that produced them.
// -----------------------------------------------------------------------------
module tb_multi_channel_frequency_divider;

  logic       clk;
  logic       rst_n;
  logic [3:0] en;
  logic       we;
  logic [1:0] ch;
  logic [7:0] half;
  logic [3:0] clk_a, tick_a;
  logic [2:0] clk_b, tick_b;

  int total = 0;
  int bad   = 0;

  multi_channel_frequency_divider #(
    .NUM_CH(4), .CH_W(2), .CNT_W(8), .DEFAULT_HALF(3)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .cfg_we_i(we), .cfg_ch_i(ch),
    .cfg_half_i(half), .clk_o(clk_a), .tick_o(tick_a)
  );

  multi_channel_frequency_divider #(
    .NUM_CH(3), .CH_W(2), .CNT_W(8), .DEFAULT_HALF(3)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_n), .en_i(en[2:0]), .cfg_we_i(we), .cfg_ch_i(ch),
    .cfg_half_i(half), .clk_o(clk_b), .tick_o(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst_before;
    logic [3:0] en;
    logic       we;
    logic [1:0] ch;
    logic [7:0] half;
    logic [3:0] exp_clk;
    logic [3:0] exp_tick;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(bit r, logic [3:0] e, logic w, logic [1:0] c,
                              logic [7:0] h, logic [3:0] xc, logic [3:0] xt);
    vec_t v;
    v.rst_before = r; v.en = e; v.we = w; v.ch = c; v.half = h;
    v.exp_clk = xc; v.exp_tick = xt;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    we    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Scenario A: reset defaults, mid-period write to ch1 (N=1), write to ch0
    // on its terminal edge (N=0). Row i = edge i+1 after reset release.
    vecs[0]  = mk(1, 4'hF, 0, 2'd0, 8'd0, 4'h0, 4'h0);
    vecs[1]  = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'h0, 4'h0);
    vecs[2]  = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'h0, 4'h0);
    vecs[3]  = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'hF, 4'hF);
    vecs[4]  = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'hF, 4'h0);
    vecs[5]  = mk(0, 4'hF, 1, 2'd1, 8'd1, 4'hF, 4'h0);
    vecs[6]  = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'hF, 4'h0);
    vecs[7]  = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'h0, 4'h0);
    vecs[8]  = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'h0, 4'h0);
    vecs[9]  = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'h2, 4'h2);
    vecs[10] = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'h2, 4'h0);
    vecs[11] = mk(0, 4'hF, 1, 2'd0, 8'd0, 4'hD, 4'hD);
    vecs[12] = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'hC, 4'h0);
    vecs[13] = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'hF, 4'h3);
    vecs[14] = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'hE, 4'h0);
    vecs[15] = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'h1, 4'h1);
    // Scenario B: ch3 disabled and written N=1 at edge 2 (count 1 -> cleared),
    // re-enabled at edge 5; ch2 paused at count 2 for edges 3..7.
    vecs[16] = mk(1, 4'hF, 0, 2'd0, 8'd0, 4'h0, 4'h0);
    vecs[17] = mk(0, 4'h7, 1, 2'd3, 8'd1, 4'h0, 4'h0);
    vecs[18] = mk(0, 4'h3, 0, 2'd0, 8'd0, 4'h0, 4'h0);
    vecs[19] = mk(0, 4'h3, 0, 2'd0, 8'd0, 4'h3, 4'h3);
    vecs[20] = mk(0, 4'hB, 0, 2'd0, 8'd0, 4'h3, 4'h0);
    vecs[21] = mk(0, 4'hB, 0, 2'd0, 8'd0, 4'hB, 4'h8);
    vecs[22] = mk(0, 4'hB, 0, 2'd0, 8'd0, 4'hB, 4'h0);
    vecs[23] = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'h0, 4'h0);
    vecs[24] = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'h4, 4'h4);
    vecs[25] = mk(0, 4'hF, 0, 2'd0, 8'd0, 4'hC, 4'h8);

    rst_n = 1'b0; en = 4'h0; we = 1'b0; ch = 2'd0; half = 8'd0;
    #1;
    check("reset clk_a",  {12'd0, clk_a},  16'h0);
    check("reset tick_a", {12'd0, tick_a}, 16'h0);
    check("reset clk_b",  {13'd0, clk_b},  16'h0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst_before) do_reset();
      en = vecs[i].en; we = vecs[i].we; ch = vecs[i].ch; half = vecs[i].half;
      step();
      check($sformatf("row%0d clk", i),  {12'd0, clk_a},  {12'd0, vecs[i].exp_clk});
      check($sformatf("row%0d tick", i), {12'd0, tick_a}, {12'd0, vecs[i].exp_tick});
    end

    // Out-of-range channel write on the 3-channel instance: nothing changes.
    do_reset();
    en = 4'hF; we = 1'b1; ch = 2'd3; half = 8'd0;
    step();
    we = 1'b0;
    check("inv e1 clk_b", {13'd0, clk_b}, 16'h0);
    for (int e = 2; e <= 9; e++) begin
      step();
      check($sformatf("inv e%0d clk_b", e), {13'd0, clk_b},
            (e >= 4 && e < 8) ? 16'h7 : 16'h0);
      check($sformatf("inv e%0d tick_b", e), {13'd0, tick_b},
            (e == 4) ? 16'h7 : 16'h0);
    end

    // Asynchronous reset while every clk_o is high.
    do_reset();
    en = 4'hF;
    repeat (4) step();
    check("pre-rst clk_a", {12'd0, clk_a}, 16'hF);
    rst_n = 1'b0;
    #1;
    check("async clk_a",  {12'd0, clk_a},  16'h0);
    check("async tick_a", {12'd0, tick_a}, 16'h0);
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("post-rst e%0d clk", e),  {12'd0, clk_a},
            (e == 4) ? 16'hF : 16'h0);
      check($sformatf("post-rst e%0d tick", e), {12'd0, tick_a},
            (e == 4) ? 16'hF : 16'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
